// File: rtl/battle_sequencer.sv
// battle_sequencer: turn, HP and outcome controller for the battle screen.
// Define BATTLE_IFRAME_EN to build the post-hit invincibility timer.
module battle_sequencer #(
  parameter int HP_MAX        = 20,
  parameter int DAMAGE        = 4,
  parameter int IFRAME_CYCLES = 32500000,
  parameter int TURN_MAX      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_in,
  input  logic       player_done_in,
  input  logic       enemy_busy_in,
  input  logic       enemy_finished_in,
  input  logic       damage_in,
  output logic [3:0] state_out,
  output logic [3:0] turn_out,
  output logic [7:0] hp_out,
  output logic       invincible_out,
  output logic       game_over_out,
  output logic       victory_out
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0000,
    S_PLAYER = 4'b0100,
    S_ENEMY  = 4'b1000,
    S_WIN    = 4'b1110,
    S_LOSE   = 4'b1111
  } state_t;

  localparam logic [7:0] HP_INIT   = 8'(HP_MAX);
  localparam logic [7:0] DMG       = 8'(DAMAGE);
  localparam logic [3:0] TURN_LAST = 4'(TURN_MAX - 1);

  state_t     state;
  logic [3:0] turn;
  logic [7:0] hp;
  logic       hit_ok;
  logic       hit;
  logic       lethal;
  logic       dbg_busy_unused;

  assign hit    = damage_in && (state == S_ENEMY) && hit_ok;
  assign lethal = hit && (hp <= DMG);

`ifdef BATTLE_IFRAME_EN
  localparam int CW = (IFRAME_CYCLES > 1) ? $clog2(IFRAME_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(IFRAME_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          inv_q;

  // inv_q trails the counter by one edge so the window spans IFRAME_CYCLES
  assign hit_ok         = !inv_q;
  assign invincible_out = inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      inv_q <= 1'b0;
    end else if (state == S_IDLE && start_in) begin
      cnt   <= '0;
      inv_q <= 1'b0;
    end else if (hit) begin
      cnt   <= CNT_LOAD;
      inv_q <= 1'b1;
    end else begin
      if (cnt != '0)
        cnt <= cnt - CW'(1);
      inv_q <= (cnt != '0);
    end
  end
`else
  assign hit_ok         = 1'b1;
  assign invincible_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      turn            <= '0;
      hp              <= HP_INIT;
      dbg_busy_unused <= 1'b0;
    end else begin
      dbg_busy_unused <= enemy_busy_in;
      if (hit)
        hp <= lethal ? 8'd0 : hp - DMG;
      unique case (state)
        S_IDLE:
          if (start_in) begin
            state <= S_PLAYER;
            hp    <= HP_INIT;
            turn  <= '0;
          end
        S_PLAYER:
          if (player_done_in)
            state <= S_ENEMY;
        // a lethal hit wins over a simultaneous finish
        S_ENEMY:
          if (lethal) begin
            state <= S_LOSE;
          end else if (enemy_finished_in) begin
            if (turn == TURN_LAST) begin
              state <= S_WIN;
            end else begin
              turn  <= turn + 4'd1;
              state <= S_PLAYER;
            end
          end
        S_WIN, S_LOSE:
          if (start_in)
            state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
  end

  assign state_out     = state;
  assign turn_out      = turn;
  assign hp_out        = hp;
  assign game_over_out = (state == S_LOSE);
  assign victory_out   = (state == S_WIN);

endmodule
